// File: rtl/axis_pkg.sv
// axis_pkg: shared stream defaults and width helper for the ready-pipe buffer
package axis_pkg;
    localparam int AXIS_DATA_WIDTH = 32;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/axis_sync_fifo_mem.sv
// axis_sync_fifo_mem: register-array storage with one write port and a combinational read port
module axis_sync_fifo_mem
    import axis_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    always_comb begin
        mem_d = mem_q;
        mem_d[waddr] = we ? wdata : mem_q[waddr];
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/axis_ready_pipe_buffer.sv
// axis_ready_pipe_buffer: FIFO that absorbs in-flight beats so upstream ready is a pure register
module axis_ready_pipe_buffer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH    = AXIS_DATA_WIDTH,
    parameter int READY_LATENCY = 1,
    parameter int DEPTH         = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [clog2(DEPTH+1)-1:0]  fill_level
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two");
    end
    if (DEPTH < READY_LATENCY + 2) begin : g_small_depth
        $error("DEPTH must be at least READY_LATENCY + 2");
    end
    if (READY_LATENCY < 1 || READY_LATENCY > 8) begin : g_bad_latency
        $error("READY_LATENCY must be within 1..8");
    end
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [READY_LATENCY-1:0] rdy_q, rdy_d;
    logic                     push, pop, space_ok;
    logic [DATA_WIDTH:0]      head;
    always_comb begin
        push     = s_axis_tvalid && rdy_q[READY_LATENCY-1];
        pop      = (count_q != '0) && m_axis_tready;
        // room must cover every beat still accepted while the stale ready drains
        space_ok = (CW'(DEPTH) - count_q) > CW'(READY_LATENCY);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        rdy_d    = (rdy_q << 1) | READY_LATENCY'(space_ok);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
        end
    end
    axis_sync_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({s_axis_tlast, s_axis_tdata}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );
    assign s_axis_tready = rdy_q[READY_LATENCY-1];
    assign m_axis_tvalid = count_q != '0;
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = head[DATA_WIDTH];
    assign fill_level    = count_q;
endmodule

// File: tb/tb_axis_ready_pipe_buffer.sv
// tb_axis_ready_pipe_buffer: directed and random checks of two buffer configs against a queue model
module tb_axis_ready_pipe_buffer;
    logic clk = 0;
    logic rst = 1;
    logic sv [2], sl [2], mr [2], sr [2], mv [2], ml [2];
    logic [31:0] sd [2], md [2];
    logic [3:0] fill_a;
    logic [4:0] fill_b;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    axis_ready_pipe_buffer #(.DATA_WIDTH(32), .READY_LATENCY(1), .DEPTH(8)) u_a (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(sv[0]), .s_axis_tdata(sd[0]), .s_axis_tlast(sl[0]), .s_axis_tready(sr[0]),
        .m_axis_tvalid(mv[0]), .m_axis_tdata(md[0]), .m_axis_tlast(ml[0]), .m_axis_tready(mr[0]),
        .fill_level(fill_a)
    );
    axis_ready_pipe_buffer #(.DATA_WIDTH(32), .READY_LATENCY(3), .DEPTH(16)) u_b (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(sv[1]), .s_axis_tdata(sd[1]), .s_axis_tlast(sl[1]), .s_axis_tready(sr[1]),
        .m_axis_tvalid(mv[1]), .m_axis_tdata(md[1]), .m_axis_tlast(ml[1]), .m_axis_tready(mr[1]),
        .fill_level(fill_b)
    );

    // Model: a ring of stored beats plus a log of occupancy per cycle since reset.
    int msize [2], mhead [2], edges [2];
    logic [32:0] mbuf [2][64];
    int ch [2][16];

    function automatic int lat(input int i);
        return i == 0 ? 1 : 3;
    endfunction
    function automatic int dep(input int i);
        return i == 0 ? 8 : 16;
    endfunction
    function automatic bit exp_rdy(input int i);
        if (edges[i] < lat(i)) return 0;
        return (dep(i) - ch[i][(edges[i] - lat(i)) % 16]) > lat(i);
    endfunction
    function automatic bit m_push(input int i);
        return sv[i] && exp_rdy(i);
    endfunction
    function automatic bit m_pop(input int i);
        return msize[i] != 0 && mr[i];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                msize[i] <= 0;
                mhead[i] <= 0;
                edges[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ch[i][edges[i] % 16] <= msize[i];
                if (m_pop(i)) mhead[i] <= (mhead[i] + 1) % 64;
                if (m_push(i)) mbuf[i][(mhead[i] + msize[i]) % 64] <= {sl[i], sd[i]};
                msize[i] <= msize[i] + int'(m_push(i)) - int'(m_pop(i));
                edges[i] <= edges[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("fill_level", i, 64'(i == 0 ? {1'b0, fill_a} : fill_b), 64'(msize[i]));
            chk("m_tvalid", i, 64'(mv[i]), 64'(msize[i] != 0));
            chk("s_tready", i, 64'(sr[i]), 64'(exp_rdy(i)));
            if (msize[i] != 0) begin
                chk("m_tdata", i, 64'(md[i]), 64'(mbuf[i][mhead[i]][31:0]));
                chk("m_tlast", i, 64'(ml[i]), 64'(mbuf[i][mhead[i]][32]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int val, acc, prev_fill, drop_fill, got, sent, outs, first, lastc, n;
        bit seen, took;
        logic r0, r1;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 0; sl[i] = 0; sd[i] = 0; mr[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", 0, 64'(sr[0]), 0);
        chk("rst_valid", 0, 64'(mv[0]), 0);
        chk("rst_fill", 0, 64'(fill_a), 0);
        tick();
        rst = 0;
        chk("rel_ready0", 0, 64'(sr[0]), 0);
        tick();
        chk("rel_ready1", 0, 64'(sr[0]), 1);
        chk("rel_ready1", 1, 64'(sr[1]), 0);
        tick();
        tick();
        chk("rel_ready3", 1, 64'(sr[1]), 1);

        // Backpressure fill on the L=1 / DEPTH=8 instance
        val = 1; acc = 0; prev_fill = 0; drop_fill = -1;
        sv[0] = 1;
        for (int c = 0; c < 14; c++) begin
            sd[0] = val;
            sl[0] = val == 8;
            @(negedge clk);
            if (sr[0]) begin
                acc++;
                val++;
            end else if (drop_fill < 0) drop_fill = prev_fill;
            prev_fill = int'(fill_a);
            tick();
        end
        sv[0] = 0;
        chk("accepted", 0, 64'(acc), 8);
        chk("drop_after_fill", 0, 64'(drop_fill), 7);
        chk("full_fill", 0, 64'(fill_a), 8);
        chk("full_ready", 0, 64'(sr[0]), 0);

        mr[0] = 1; got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mv[0]) begin
                chk("drain_data", 0, 64'(md[0]), 64'(got + 1));
                chk("drain_last", 0, 64'(ml[0]), 64'(got == 7));
                got++;
            end
            tick();
        end
        chk("drained", 0, 64'(got), 8);
        chk("empty_valid", 0, 64'(mv[0]), 0);
        chk("resume_ready", 0, 64'(sr[0]), 1);
        mr[0] = 0;

        // Streaming on the L=3 / DEPTH=16 instance
        mr[1] = 1; sent = 0; outs = 0; first = -1; lastc = -1;
        for (int c = 0; c < 200 && outs < 64; c++) begin
            sd[1] = 100 + sent;
            sl[1] = sent == 63;
            sv[1] = sent < 64;
            @(negedge clk);
            if (mv[1]) begin
                chk("stream_data", 1, 64'(md[1]), 64'(100 + outs));
                if (first < 0) first = c;
                lastc = c;
                outs++;
            end
            if (sv[1] && sr[1]) sent++;
            tick();
        end
        sv[1] = 0; mr[1] = 0;
        chk("stream_beats", 1, 64'(outs), 64);
        chk("stream_span", 1, 64'(lastc - first + 1), 64);

        // Random traffic, alternating downstream pressure to hit full and empty
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                sv[i] = $urandom_range(0, 3) != 0;
                sd[i] = $urandom;
                sl[i] = $urandom_range(0, 1);
                mr[i] = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            end
            #2;
            r0 = sr[0]; r1 = sr[1];
            mr[0] = ~mr[0]; mr[1] = ~mr[1];
            #1;
            chk("rdy_indep", 0, 64'(sr[0]), 64'(r0));
            chk("rdy_indep", 1, 64'(sr[1]), 64'(r1));
            mr[0] = ~mr[0]; mr[1] = ~mr[1];
            tick();
        end

        for (int i = 0; i < 2; i++) begin
            sv[i] = 0; sl[i] = 0; mr[i] = 1;
        end
        repeat (24) tick();
        mr[0] = 0; mr[1] = 0;

        // Reset in the middle of a burst with five beats held
        sv[0] = 1; n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            sd[0] = 32'hA0 + n;
            @(negedge clk);
            if (sr[0]) n++;
            tick();
        end
        sv[0] = 0;
        chk("stored", 0, 64'(fill_a), 5);
        #3;
        rst = 1;
        #1;
        chk("mid_rst_valid", 0, 64'(mv[0]), 0);
        chk("mid_rst_fill", 0, 64'(fill_a), 0);
        chk("mid_rst_ready", 0, 64'(sr[0]), 0);
        tick();
        rst = 0;
        sv[0] = 1; sd[0] = 32'hBEEF; sl[0] = 1; mr[0] = 1; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mv[0]) begin
                chk("post_rst_first", 0, 64'(md[0]), 64'h0000BEEF);
                seen = 1;
            end
            took = sv[0] && sr[0];
            tick();
            if (took) sv[0] = 0;
        end
        chk("post_rst_seen", 0, 64'(seen), 1);
        sv[0] = 0;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
